// File: rtl/step_controller.sv
// Clock-enable generator for the single-cycle core: debounced single-step, divided free-run,
// and a PC breakpoint that halts free-run. The core runs on iCLK and advances only on cpu_en.
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 5000000,
    parameter int CNT_W           = 16
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             key_step_n,
    input  logic             run_mode,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic             clr_count,
    output logic             cpu_en,
    output logic             halted,
    output logic             running,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       state_dbg
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       key_sync;
    logic [1:0]       run_sync;
    logic             key_s;
    logic             run_s;
    logic [DB_W-1:0]  db_cnt;
    logic             key_db;
    logic             key_db_d;
    logic             press;
    logic             bp_hit;
    logic [DIV_W-1:0] div_cnt;

    assign key_s     = key_sync[1];
    assign run_s     = run_sync[1];
    assign press     = key_db_d & ~key_db;
    assign bp_hit    = bp_en && (pc == bp_addr);
    assign state_dbg = state;

    // Key resets to "released" so a reset never manufactures a press.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            key_sync <= 2'b11;
            run_sync <= 2'b00;
        end else begin
            key_sync <= {key_sync[0], key_step_n};
            run_sync <= {run_sync[0], run_mode};
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            db_cnt   <= '0;
            key_db   <= 1'b1;
            key_db_d <= 1'b1;
        end else begin
            key_db_d <= key_db;
            if (key_s == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Breakpoint is evaluated before the divider tick, so a hit never issues a pulse.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            cpu_en  <= 1'b0;
            running <= 1'b0;
            halted  <= 1'b0;
            div_cnt <= '0;
        end else begin
            cpu_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_s) begin
                        state   <= RUN;
                        running <= 1'b1;
                        div_cnt <= '0;
                    end else if (press) begin
                        cpu_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run_s) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (bp_hit) begin
                        state   <= HALT;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        cpu_en  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HALT: begin
                    if (!run_s) begin
                        state  <= IDLE;
                        halted <= 1'b0;
                    end else if (press) begin
                        cpu_en <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            step_count <= '0;
        end else if (clr_count) begin
            step_count <= '0;
        end else if (cpu_en) begin
            step_count <= step_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: directed scenarios plus random key/run/breakpoint traffic,
// checked every cycle against a window/modulo reference model of the stepping rules.
module tb_step_controller;

    localparam int DB  = 4;
    localparam int DIV = 5;
    localparam int CW  = 4;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          key_step_n = 1'b1;
    logic          run_mode   = 1'b0;
    logic          bp_en      = 1'b0;
    logic          clr_count  = 1'b0;
    logic [31:0]   bp_addr    = 32'd0;
    logic [31:0]   pc         = 32'd0;
    logic          pc_load    = 1'b0;
    logic [31:0]   pc_val     = 32'd0;
    logic          cpu_en;
    logic          halted;
    logic          running;
    logic [CW-1:0] step_count;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_err    = 0;
    int n_pulses = 0;

    step_controller #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (DIV),
        .CNT_W          (CW)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .key_step_n(key_step_n),
        .run_mode  (run_mode),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .clr_count (clr_count),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .running   (running),
        .step_count(step_count),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // CPU stand-in: pc register advanced only by cpu_en
    always @(posedge clk) begin
        if (pc_load) pc <= pc_val;
        else if (cpu_en) pc <= pc + 32'd4;
        if (cpu_en) n_pulses <= n_pulses + 1;
    end

    // reference model: mode 0=IDLE 1=RUN 2=HALT
    logic [31:0]   exp_q[$];
    logic          m_ks1, m_ks2, m_rs1, m_rs2, m_db, m_press, m_en;
    logic [DB-1:0] m_hist;
    int            m_hist_n;
    logic [1:0]    m_mode;
    int            m_ticks;
    logic [CW-1:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        logic          nen;
        logic [1:0]    nmode;
        int            nticks;
        logic [DB-1:0] win;
        int            nvalid;
        logic          db_new;
        logic          press_new;
        if (!rst_n) begin
            m_ks1 <= 1'b1; m_ks2 <= 1'b1; m_rs1 <= 1'b0; m_rs2 <= 1'b0;
            m_db <= 1'b1; m_press <= 1'b0; m_en <= 1'b0;
            m_hist <= '0; m_hist_n <= 0; m_mode <= 2'd0; m_ticks <= 0; m_cnt <= '0;
            exp_q.delete();
        end else begin
            nen = 1'b0;
            nmode = m_mode;
            nticks = m_ticks;
            case (m_mode)
                2'd0: if (m_rs2) begin nmode = 2'd1; nticks = 0; end
                      else if (m_press) nen = 1'b1;
                2'd1: if (!m_rs2) nmode = 2'd0;
                      else if (bp_en && pc == bp_addr) nmode = 2'd2;
                      else begin nen = ((m_ticks % DIV) == DIV - 1); nticks = m_ticks + 1; end
                default: if (!m_rs2) nmode = 2'd0;
                         else if (m_press) nen = 1'b1;
            endcase
            // key accepted once the last DB synced samples all disagree with it
            win = {m_hist[DB-2:0], m_ks2};
            nvalid = (m_hist_n + 1 > DB) ? DB : m_hist_n + 1;
            db_new = m_db;
            press_new = 1'b0;
            if (nvalid == DB && win == {DB{~m_db}}) begin
                db_new = ~m_db;
                press_new = m_db;
            end
            if (nen) exp_q.push_back(pc);
            m_cnt <= clr_count ? '0 : m_cnt + CW'(m_en);
            m_en <= nen; m_mode <= nmode; m_ticks <= nticks;
            m_db <= db_new; m_press <= press_new; m_hist <= win; m_hist_n <= nvalid;
            m_ks1 <= key_step_n; m_ks2 <= m_ks1; m_rs1 <= run_mode; m_rs2 <= m_rs1;
        end
    end

    // scoreboard: lockstep compare on the falling edge
    always @(negedge clk) begin
        check("cpu_en", cpu_en, m_en);
        check("running", running, m_mode == 2'd1);
        check("halted", halted, m_mode == 2'd2);
        check("step_count", step_count, m_cnt);
        check("state", state_dbg, m_mode);
        if (cpu_en) begin
            check("pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("pulse_pc", pc, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_pc(input logic [31:0] v);
        @(negedge clk); pc_val = v; pc_load = 1'b1;
        @(negedge clk); pc_load = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        while (n_pulses < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("wait_pulses_timeout", n_pulses >= target, 1);
    endtask

    initial begin
        int            first;
        int            hi;
        int            base;
        int            budget;
        int            hold;
        logic [5:0]    pat;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_running", running, 0);
        check("rst_halted", halted, 0);
        check("rst_count", step_count, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        cycles(2);

        // press latency and width
        key_step_n = 1'b0;
        first = 0;
        hi = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (cpu_en) begin
                hi++;
                if (first == 0) first = e;
            end
        end
        check("press_latency", first, 7);
        check("pulse_width", hi, 1);
        @(negedge clk);
        check("count_after_1", step_count, 1);
        key_step_n = 1'b1; cycles(10);
        key_step_n = 1'b0; cycles(10);
        check("count_after_2", step_count, 2);
        key_step_n = 1'b1; cycles(10);

        // short glitch, then bounce
        key_step_n = 1'b0; cycles(3);
        key_step_n = 1'b1; cycles(10);
        check("glitch_ignored", step_count, 2);
        pat = 6'b000010;
        for (int i = 0; i < 6; i++) begin
            key_step_n = pat[i];
            @(negedge clk);
        end
        cycles(8);
        check("bounce_one_pulse", step_count, 3);
        key_step_n = 1'b1; cycles(10);

        // free-run and counter wrap
        clr_count = 1'b1; @(negedge clk); clr_count = 1'b0;
        check("clr", step_count, 0);
        load_pc(32'd0);
        bp_en = 1'b0;
        run_mode = 1'b1;
        base = n_pulses;
        wait_pulses(base + 16, 120);
        check("wrap_count", step_count, 0);
        check("run_pc", pc, 32'h40);
        run_mode = 1'b0;
        cycles(3);
        base = n_pulses;
        cycles(20);
        check("stopped_pulses", n_pulses, base);
        check("stopped_running", running, 0);

        // breakpoint
        load_pc(32'd0);
        bp_en = 1'b1;
        bp_addr = 32'h10;
        base = n_pulses;
        run_mode = 1'b1;
        budget = 60;
        while (!halted && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("halt_timeout", halted, 1);
        check("bp_pulses", n_pulses - base, 4);
        check("bp_pc", pc, 32'h10);
        key_step_n = 1'b0; cycles(12);
        check("step_past_pc", pc, 32'h14);
        check("still_halted", halted, 1);
        key_step_n = 1'b1; cycles(8);
        run_mode = 1'b0; cycles(4);
        check("halt_to_idle", state_dbg, 0);
        run_mode = 1'b1; cycles(4);
        check("rerun", running, 1);
        wait_pulses(n_pulses + 1, 20);
        check("rerun_pc", pc, 32'h18);

        // asynchronous reset mid-RUN
        cycles(2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cpu_en", cpu_en, 0);
        check("arst_running", running, 0);
        check("arst_count", step_count, 0);
        check("arst_state", state_dbg, 0);
        @(negedge clk); rst_n = 1'b1;
        cycles(2);
        check("no_run_before_resync", running, 0);
        cycles(8);
        check("run_after_resync", running, 1);

        // clear coincident with a pulse
        budget = 20;
        while (!cpu_en && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("clr_pulse_timeout", cpu_en, 1);
        clr_count = 1'b1; @(negedge clk); clr_count = 1'b0;
        check("clr_wins", step_count, 0);
        run_mode = 1'b0;
        cycles(5);

        // random traffic
        for (int s = 0; s < 70; s++) begin
            key_step_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) run_mode = ~run_mode;
            bp_en = 1'($urandom_range(0, 1));
            bp_addr = pc + 32'(4 * $urandom_range(0, 3));
            clr_count = ($urandom_range(0, 15) == 0);
            hold = $urandom_range(1, 10);
            @(negedge clk);
            clr_count = 1'b0;
            cycles(hold - 1);
        end
        run_mode = 1'b0;
        key_step_n = 1'b1;
        cycles(12);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
